// File: rtl/circuito_exp_7.sv
// circuito_exp_7: memory game ("Genius") top level.
// FSM, address/round counters, 16x4 step RAM, button edge capture,
// show/timeout counter and active-low 7-segment debug decoders.
// Optional feature macro: TIMEOUT_EN (per-move timeout; off by default).
module circuito_exp_7 #(
    parameter int SHOW_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] botoes,
    output logic [3:0] leds,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_clock,
    output logic       db_tem_jogada,
    output logic       db_igual,
    output logic       db_enderecoIgualRodada,
    output logic       db_timeout,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_jogadafeita,
    output logic [6:0] db_rodada,
    output logic [6:0] db_estado
);

    localparam logic [3:0] INICIAL     = 4'h0;
    localparam logic [3:0] PREPARA     = 4'h1;
    localparam logic [3:0] MOSTRA      = 4'h2;
    localparam logic [3:0] ESPERA      = 4'h3;
    localparam logic [3:0] REGISTRA    = 4'h4;
    localparam logic [3:0] COMPARA     = 4'h5;
    localparam logic [3:0] PROX_JOGADA = 4'h6;
    localparam logic [3:0] ESPERA_NOVA = 4'h7;
    localparam logic [3:0] ESCREVE     = 4'h8;
    localparam logic [3:0] PROX_RODADA = 4'h9;
    localparam logic [3:0] GANHOU      = 4'hA;
    localparam logic [3:0] TIMEOUT     = 4'hD;
    localparam logic [3:0] PERDEU      = 4'hE;

    // First step of every game; address 0 is never written, so it is a constant.
    localparam logic [3:0] RAM0 = 4'b0001;

    // One counter times the show phase and (optionally) each move.
    localparam int MAXC = (SHOW_CYCLES > TIMEOUT_CYCLES) ? SHOW_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYCLES - 1);

    logic [3:0]    estado_q, estado_d;
    logic [3:0]    addr_q, addr_d;
    logic [3:0]    round_q, round_d;
    logic [3:0]    jogada_q, jogada_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q;
    logic [3:0]    mem_q [16];
    logic [3:0]    ram_out;
    logic          tem, cap, waiting, igual, show_end, tmo_end;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign tem      = |botoes;
    assign waiting  = (estado_q == ESPERA) || (estado_q == ESPERA_NOVA);
    // One capture per press: only the 0->1 transition of |botoes counts.
    assign cap      = waiting && tem && !prev_q;
    assign ram_out  = (addr_q == 4'd0) ? RAM0 : mem_q[addr_q];
    assign igual    = (jogada_q == ram_out);
    assign show_end = (estado_q == MOSTRA) && (cnt_q == SHOW_LAST);

`ifdef TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    assign tmo_end    = waiting && (cnt_q == TMO_LAST);
    assign db_timeout = (estado_q == TIMEOUT);
`else
    assign tmo_end    = 1'b0;
    assign db_timeout = 1'b0;
`endif

    // Counter: runs through the show phase; in waiting states it restarts on entry and on every capture.
    always_comb begin
        cnt_d = '0;
        if (estado_q == MOSTRA && !show_end)
            cnt_d = cnt_q + CW'(1);
`ifdef TIMEOUT_EN
        else if (waiting && !cap)
            cnt_d = cnt_q + CW'(1);
`endif
    end

    // Game sequencing.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL, GANHOU, PERDEU, TIMEOUT: if (iniciar) estado_d = PREPARA;
            PREPARA:     estado_d = MOSTRA;
            MOSTRA:      if (show_end) estado_d = ESPERA;
            ESPERA: begin
                if (cap)          estado_d = REGISTRA;
                else if (tmo_end) estado_d = TIMEOUT;
            end
            REGISTRA:    estado_d = COMPARA;
            COMPARA: begin
                if (!igual)                 estado_d = PERDEU;
                else if (addr_q < round_q)  estado_d = PROX_JOGADA;
                else if (round_q == 4'd15)  estado_d = GANHOU;
                else                        estado_d = ESPERA_NOVA;
            end
            PROX_JOGADA: estado_d = ESPERA;
            ESPERA_NOVA: begin
                if (cap)          estado_d = ESCREVE;
                else if (tmo_end) estado_d = TIMEOUT;
            end
            ESCREVE:     estado_d = PROX_RODADA;
            PROX_RODADA: estado_d = ESPERA;
            default:     estado_d = INICIAL;
        endcase
    end

    // Address, round and captured-move updates.
    always_comb begin
        addr_d   = addr_q;
        round_d  = round_q;
        jogada_d = jogada_q;
        case (estado_q)
            PREPARA: begin
                addr_d   = 4'd0;
                round_d  = 4'd0;
                jogada_d = 4'd0;
            end
            PROX_JOGADA: addr_d = addr_q + 4'd1;
            PROX_RODADA: begin
                round_d = round_q + 4'd1;
                addr_d  = 4'd0;
            end
            default: ;
        endcase
        if (cap) jogada_d = botoes;
    end

    // Control state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
            addr_q   <= 4'd0;
            round_q  <= 4'd0;
            jogada_q <= 4'd0;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
        end else begin
            estado_q <= estado_d;
            addr_q   <= addr_d;
            round_q  <= round_d;
            jogada_q <= jogada_d;
            cnt_q    <= cnt_d;
            prev_q   <= tem;
        end
    end

    // Step RAM: not reset, so the sequence survives a new game. Round never exceeds 14 here.
    always_ff @(posedge clock) begin
        if (estado_q == ESCREVE)
            mem_q[round_q + 4'd1] <= jogada_q;
    end

    assign leds   = (estado_q == MOSTRA) ? RAM0 : botoes;
    assign ganhou = (estado_q == GANHOU);
    assign perdeu = (estado_q == PERDEU) || (estado_q == TIMEOUT);
    assign pronto = ganhou || perdeu;

    assign db_clock      = clock;
    assign db_tem_jogada = tem;
    assign db_igual      = igual;
    // Counters both sit at 0 while idle; suppress the trivial match until a game starts.
    assign db_enderecoIgualRodada = (addr_q == round_q) && (estado_q != INICIAL);

    assign db_contagem    = hex7(addr_q);
    assign db_memoria     = hex7(ram_out);
    assign db_jogadafeita = hex7(jogada_q);
    assign db_rodada      = hex7(round_q);
    assign db_estado      = hex7(estado_q);

endmodule

// File: tb/tb_circuito_exp_7.sv
// Bench for circuito_exp_7: table of moves per game, scoreboard queue
// popped at the cycle each move becomes visible, plus corner sequences.
module tb_circuito_exp_7;
    localparam int SC = 1000;
    localparam int TC = 3000;

    // Active-high gfedcba hex patterns; the DUT drives their complement.
    localparam logic [6:0] HEX_HI [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic [3:0] SEQ [16] = '{4'b0001, 4'b0100, 4'b0001, 4'b1000, 4'b1000, 4'b0100,
                                        4'b0100, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0010,
                                        4'b0100, 4'b1000, 4'b0100, 4'b0100};

    logic       clock = 1'b0;
    logic       reset, iniciar;
    logic [3:0] botoes, leds;
    logic       pronto, ganhou, perdeu, db_clock, db_tem_jogada, db_igual;
    logic       db_enderecoIgualRodada, db_timeout;
    logic [6:0] db_contagem, db_memoria, db_jogadafeita, db_rodada, db_estado;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] btn;
        int         hold;
        logic       nova;
        logic [3:0] addr;
        logic [3:0] rnd;
        logic [3:0] mem;
        logic       igual;
        logic [3:0] post_st;
        logic [3:0] post_addr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    circuito_exp_7 #(.SHOW_CYCLES(SC), .TIMEOUT_CYCLES(TC)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes), .leds(leds),
        .pronto(pronto), .ganhou(ganhou), .perdeu(perdeu), .db_clock(db_clock),
        .db_tem_jogada(db_tem_jogada), .db_igual(db_igual),
        .db_enderecoIgualRodada(db_enderecoIgualRodada), .db_timeout(db_timeout),
        .db_contagem(db_contagem), .db_memoria(db_memoria), .db_jogadafeita(db_jogadafeita),
        .db_rodada(db_rodada), .db_estado(db_estado));

    always #5 clock = ~clock;

    function automatic logic [6:0] seg(input logic [3:0] v);
        return ~HEX_HI[v];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Builds the move table of one game up to last_round; bad_a >= 0 makes that move wrong.
    task automatic build_game(input int last_round, input int bad_a, input logic [3:0] bad_btn);
        vec_t v;
        vecs.delete();
        for (int r = 0; r <= last_round; r++) begin
            for (int a = 0; a <= r; a++) begin
                v.btn   = (r == last_round && a == bad_a) ? bad_btn : SEQ[a];
                v.hold  = (r == 1 && a == 0) ? 10 : 2;
                v.nova  = 1'b0;
                v.addr  = 4'(a);
                v.rnd   = 4'(r);
                v.mem   = SEQ[a];
                v.igual = (v.btn == SEQ[a]);
                v.post_addr = 4'(a);
                if (!v.igual)     v.post_st = 4'hE;
                else if (a < r) begin
                    v.post_st   = 4'h3;
                    v.post_addr = 4'(a + 1);
                end
                else if (r == 15) v.post_st = 4'hA;
                else              v.post_st = 4'h7;
                vecs.push_back(v);
                if (!v.igual) return;
            end
            if (r < 15) begin
                v.btn = SEQ[r + 1]; v.hold = 2; v.nova = 1'b1; v.addr = 4'(r);
                v.rnd = 4'(r); v.mem = 4'd0; v.igual = 1'b0;
                v.post_st = 4'h3; v.post_addr = 4'd0;
                vecs.push_back(v);
            end
        end
    endtask

    task automatic press(input vec_t v);
        vec_t e;
        sb.push_back(v);
        botoes = v.btn;
        tick();
        chk("leds_mirror", leds, v.btn);
        chk("tem_jogada", db_tem_jogada, 1);
        if (v.nova) begin
            e = sb.pop_front();
            chk("escreve_state", db_estado, seg(4'h8));
            chk("escreve_move", db_jogadafeita, seg(e.btn));
            chk("escreve_round", db_rodada, seg(e.rnd));
        end
        tick();
        if (!v.nova) begin
            e = sb.pop_front();
            chk("compara_state", db_estado, seg(4'h5));
            chk("compara_igual", db_igual, e.igual);
            chk("compara_addr", db_contagem, seg(e.addr));
            chk("compara_mem", db_memoria, seg(e.mem));
            chk("compara_round", db_rodada, seg(e.rnd));
            chk("compara_move", db_jogadafeita, seg(e.btn));
            chk("addr_eq_round", db_enderecoIgualRodada, (e.addr == e.rnd));
        end
        repeat (v.hold - 2) tick();
        botoes = 4'd0;
        repeat (4) tick();
        chk("post_state", db_estado, seg(v.post_st));
        chk("post_addr", db_contagem, seg(v.post_addr));
    endtask

    task automatic start_game();
        iniciar = 1'b1;
        tick();
        chk("prepara_state", db_estado, seg(4'h1));
        tick();
        chk("mostra_state", db_estado, seg(4'h2));
        chk("mostra_leds", leds, 4'b0001);
        chk("mostra_round", db_rodada, seg(4'h0));
        chk("mostra_addr", db_contagem, seg(4'h0));
        chk("mostra_ram0", db_memoria, seg(4'h1));
        for (int i = 2; i <= SC; i++) begin
            if (i == 5) iniciar = 1'b0;
            tick();
        end
        chk("mostra_last_leds", leds, 4'b0001);
        chk("mostra_last_state", db_estado, seg(4'h2));
        tick();
        chk("espera_state", db_estado, seg(4'h3));
        chk("espera_leds", leds, 4'b0000);
    endtask

    initial begin
        vec_t v;
        reset = 1'b0; iniciar = 1'b0; botoes = 4'd0;
        tick();
        chk("rst_state", db_estado, seg(4'h0));
        chk("rst_pronto", pronto, 0);
        chk("rst_ganhou", ganhou, 0);
        chk("rst_perdeu", perdeu, 0);
        chk("rst_timeout", db_timeout, 0);
        chk("rst_leds", leds, 0);
        chk("rst_eq_round", db_enderecoIgualRodada, 0);
        chk("rst_igual", db_igual, 0);
        chk("rst_round", db_rodada, seg(4'h0));
        chk("db_clock", db_clock, clock);
        reset = 1'b1;
        repeat (3) tick();
        chk("idle_state", db_estado, seg(4'h0));

        // Full winning game.
        start_game();
        build_game(15, -1, 4'd0);
        foreach (vecs[i]) press(vecs[i]);
        chk("win_ganhou", ganhou, 1);
        chk("win_pronto", pronto, 1);
        chk("win_perdeu", perdeu, 0);
        repeat (5) tick();
        chk("win_hold_state", db_estado, seg(4'hA));

        // New game keeps RAM; iniciar during play ignored; loses at round 3 move 2.
        start_game();
        iniciar = 1'b1;
        repeat (3) tick();
        iniciar = 1'b0;
        chk("iniciar_ignored", db_estado, seg(4'h3));
        build_game(3, 2, 4'b0010);
        foreach (vecs[i]) press(vecs[i]);
        chk("lose_perdeu", perdeu, 1);
        chk("lose_pronto", pronto, 1);
        chk("lose_ganhou", ganhou, 0);
        chk("lose_timeout", db_timeout, 0);

        // Idle wait in ESPERA.
        start_game();
        repeat (TC - 1) tick();
        chk("tmo_before", db_estado, seg(4'h3));
        tick();
`ifdef TIMEOUT_EN
        chk("tmo_state", db_estado, seg(4'hD));
        chk("tmo_perdeu", perdeu, 1);
        chk("tmo_flag", db_timeout, 1);
        chk("tmo_pronto", pronto, 1);
        start_game();
`else
        chk("no_tmo_state", db_estado, seg(4'h3));
        chk("no_tmo_flag", db_timeout, 0);
        chk("no_tmo_perdeu", perdeu, 0);
`endif
        v.btn = 4'b0001; v.hold = 2; v.nova = 1'b0; v.addr = 4'd0; v.rnd = 4'd0;
        v.mem = 4'b0001; v.igual = 1'b1; v.post_st = 4'h7; v.post_addr = 4'd0;
        press(v);

        // Asynchronous reset mid-game.
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", db_estado, seg(4'h0));
        chk("async_rst_pronto", pronto, 0);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
